mem_arbiter: RTL and testbench

Two-port, round-robin arbiter that shares the single pulse-handshake memory interface between the CPU core (port 0) and a secondary requester (port 1, e.g. debug loader or DMA). It latches one-cycle request pulses from each port and issues them one at a time to downstream memory. It routes `mem_ready` and read data back to the owning port, and aborts transactions that never complete. It sits between `core` and the memory model/controller. Each port sees exactly the interface `core` already drives.

---
 rtl/mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of one pulse-handshake
// memory interface. Port 0 is the CPU core, port 1 a secondary requester
// (debug loader / DMA). Each port sees the same interface the core drives.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pN_mem_addr/_write_data  request address and store data (N = 0,1)
//   pN_mem_read_valid        one-cycle read request pulse
//   pN_mem_write_valid       one-cycle write request pulse
//   pN_mem_width             0=byte, 1=half, 2=word
//   pN_mem_ready             one-cycle completion pulse back to port N
//   pN_mem_read_data         read data, held until port N's next read completion
//   mem_*                    registered downstream request fields and pulses
//   mem_ready, mem_read_data downstream completion pulse and read data
//   protocol_error           sticky: dropped pulse or read+write on one port
//   timeout_error            sticky: watchdog aborted a transaction
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_mem_addr,
    input  logic              p0_mem_read_valid,
    input  logic              p0_mem_write_valid,
    input  logic [DATA_W-1:0] p0_mem_write_data,
    input  logic [1:0]        p0_mem_width,
    output logic              p0_mem_ready,
    output logic [DATA_W-1:0] p0_mem_read_data,
    input  logic [ADDR_W-1:0] p1_mem_addr,
    input  logic              p1_mem_read_valid,
    input  logic              p1_mem_write_valid,
    input  logic [DATA_W-1:0] p1_mem_write_data,
    input  logic [1:0]        p1_mem_width,
    output logic              p1_mem_ready,
    output logic [DATA_W-1:0] p1_mem_read_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [1:0]        mem_width,
    output logic              mem_read_valid,
    output logic              mem_write_valid,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              protocol_error,
    output logic              timeout_error
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [31:0]       WAIT_LAST  = 32'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

    state_t            state, state_nxt;

    // Incoming pulses, gathered per port so both ports share one code path.
    logic [1:0]        req_vld, req_rd, req_we;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic [1:0]        req_width [2];

    // Pending slots. The slot stays full while its transaction is in flight,
    // so "full" also covers "in flight" for the drop check.
    logic [1:0]        slot_vld, slot_we;
    logic [ADDR_W-1:0] slot_addr  [2];
    logic [DATA_W-1:0] slot_wdata [2];
    logic [1:0]        slot_width [2];

    logic              last_grant;   // port served last; reset value 1 lets port 0 win
    logic              owner;
    logic [31:0]       wait_cnt;

    logic [1:0]        cand;
    logic              grant, sel, done_ok, done_abort;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [1:0]        g_width;

    assign req_rd       = {p1_mem_read_valid, p0_mem_read_valid};
    assign req_we       = {p1_mem_write_valid, p0_mem_write_valid};
    assign req_vld      = req_rd | req_we;
    assign req_addr[0]  = p0_mem_addr;
    assign req_addr[1]  = p1_mem_addr;
    assign req_wdata[0] = p0_mem_write_data;
    assign req_wdata[1] = p1_mem_write_data;
    assign req_width[0] = p0_mem_width;
    assign req_width[1] = p1_mem_width;

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        done_ok    = 1'b0;
        done_abort = 1'b0;
        cand       = slot_vld | req_vld;
        sel        = (cand == 2'b11) ? ~last_grant : cand[1];
        // A pending slot always takes precedence over a same-cycle pulse;
        // such a pulse is being dropped anyway.
        if (slot_vld[sel]) begin
            g_we    = slot_we[sel];
            g_addr  = slot_addr[sel];
            g_wdata = slot_wdata[sel];
            g_width = slot_width[sel];
        end else begin
            g_we    = req_we[sel];
            g_addr  = req_addr[sel];
            g_wdata = req_wdata[sel];
            g_width = req_width[sel];
        end
        case (state)
            S_IDLE: begin
                if (|cand) begin
                    grant     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // mem_ready wins over the watchdog on the final count.
                if (mem_ready) begin
                    done_ok   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                    done_abort = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Slot payload: only meaningful while slot_vld is set, so no reset.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (req_vld[n] && !slot_vld[n]) begin
                slot_we[n]    <= req_we[n];
                slot_addr[n]  <= req_addr[n];
                slot_wdata[n] <= req_wdata[n];
                slot_width[n] <= req_width[n];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld         <= 2'b00;
            last_grant       <= 1'b1;
            owner            <= 1'b0;
            wait_cnt         <= '0;
            mem_addr         <= '0;
            mem_write_data   <= '0;
            mem_width        <= '0;
            mem_read_valid   <= 1'b0;
            mem_write_valid  <= 1'b0;
            p0_mem_ready     <= 1'b0;
            p1_mem_ready     <= 1'b0;
            p0_mem_read_data <= '0;
            p1_mem_read_data <= '0;
            protocol_error   <= 1'b0;
            timeout_error    <= 1'b0;
        end else begin
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            p0_mem_ready    <= 1'b0;
            p1_mem_ready    <= 1'b0;

            for (int n = 0; n < 2; n++) begin
                if (req_vld[n]) begin
                    if (slot_vld[n]) begin
                        protocol_error <= 1'b1;
                    end else begin
                        slot_vld[n] <= 1'b1;
                    end
                    if (req_rd[n] && req_we[n]) begin
                        protocol_error <= 1'b1;
                    end
                end
            end

            if (grant) begin
                mem_addr        <= g_addr;
                mem_write_data  <= g_wdata;
                mem_width       <= g_width;
                mem_write_valid <= g_we;
                mem_read_valid  <= ~g_we;
                owner           <= sel;
                wait_cnt        <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 32'd1;
            end

            // Completion or abort: the owner's slot is known full here, so
            // this clear never collides with a capture above.
            if (done_ok || done_abort) begin
                slot_vld[owner] <= 1'b0;
                if (owner) begin
                    p1_mem_ready <= 1'b1;
                end else begin
                    p0_mem_ready <= 1'b1;
                end
                if (!slot_we[owner]) begin
                    if (owner) begin
                        p1_mem_read_data <= done_ok ? mem_read_data : ABORT_DATA;
                    end else begin
                        p0_mem_read_data <= done_ok ? mem_read_data : ABORT_DATA;
                    end
                end
                if (done_ok) begin
                    last_grant <= owner;
                end
                if (done_abort) begin
                    timeout_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (TIMEOUT = 4).
// A behavioural memory answers each request one cycle after its valid pulse
// with data derived from the address. Expected downstream requests and
// per-port completions are queued when stimulus is driven and checked by a
// monitor as the DUT produces them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] p0_mem_addr, p1_mem_addr;
    logic        p0_mem_read_valid, p0_mem_write_valid;
    logic        p1_mem_read_valid, p1_mem_write_valid;
    logic [31:0] p0_mem_write_data, p1_mem_write_data;
    logic [1:0]  p0_mem_width, p1_mem_width;
    logic        p0_mem_ready, p1_mem_ready;
    logic [31:0] p0_mem_read_data, p1_mem_read_data;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [1:0]  mem_width;
    logic        mem_read_valid, mem_write_valid, mem_ready;
    logic        protocol_error, timeout_error;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .p0_mem_addr(p0_mem_addr), .p0_mem_read_valid(p0_mem_read_valid),
        .p0_mem_write_valid(p0_mem_write_valid), .p0_mem_write_data(p0_mem_write_data),
        .p0_mem_width(p0_mem_width), .p0_mem_ready(p0_mem_ready),
        .p0_mem_read_data(p0_mem_read_data),
        .p1_mem_addr(p1_mem_addr), .p1_mem_read_valid(p1_mem_read_valid),
        .p1_mem_write_valid(p1_mem_write_valid), .p1_mem_write_data(p1_mem_write_data),
        .p1_mem_width(p1_mem_width), .p1_mem_ready(p1_mem_ready),
        .p1_mem_read_data(p1_mem_read_data),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_width(mem_width),
        .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
        .mem_ready(mem_ready), .mem_read_data(mem_read_data),
        .protocol_error(protocol_error), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
    } dreq_t;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic [31:0] exp_rdata;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    dreq_t       qd[$];
    logic [31:0] qp0[$];
    logic [31:0] qp1[$];
    logic [31:0] model_rd [2];
    bit          mem_auto;
    bit          pend;
    logic [31:0] pend_addr;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h1234_5678;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int p, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        if (p == 0) begin
            p0_mem_read_valid = rd; p0_mem_write_valid = wr;
            p0_mem_addr = a; p0_mem_write_data = d; p0_mem_width = w;
        end else begin
            p1_mem_read_valid = rd; p1_mem_write_valid = wr;
            p1_mem_addr = a; p1_mem_write_data = d; p1_mem_width = w;
        end
    endtask

    task automatic clr_req(input int p);
        if (p == 0) begin
            p0_mem_read_valid = 1'b0; p0_mem_write_valid = 1'b0;
        end else begin
            p1_mem_read_valid = 1'b0; p1_mem_write_valid = 1'b0;
        end
    endtask

    task automatic exp_issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] w);
        dreq_t r;
        r.we = we; r.addr = a; r.wdata = d; r.width = w;
        qd.push_back(r);
    endtask

    task automatic exp_done(input int p, input logic [31:0] v);
        if (p == 0) qp0.push_back(v);
        else        qp1.push_back(v);
    endtask

    // Drive a request and queue everything it should produce. Writes leave
    // the port's read data as it was; a write wins over a simultaneous read.
    task automatic req(input int p, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        set_req(p, rd, wr, a, d, w);
        exp_issue(wr, a, d, w);
        if (!wr) model_rd[p] = mem_fn(a);
        exp_done(p, model_rd[p]);
    endtask

    task automatic flush();
        qd.delete(); qp0.delete(); qp1.delete();
        model_rd[0] = '0; model_rd[1] = '0;
        pend = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        flush();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((qd.size() != 0 || qp0.size() != 0 || qp1.size() != 0) && k < 100) begin
            tick();
            k++;
        end
        if (qd.size() != 0 || qp0.size() != 0 || qp1.size() != 0) begin
            flag({nm, " completion wait expired"});
            qd.delete(); qp0.delete(); qp1.delete();
        end
        tick(); tick();
    endtask

    task automatic monitor();
        logic [31:0] e;
        dreq_t       d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (p0_mem_ready) begin
                    if (qp0.size() == 0) flag("p0 unexpected mem_ready");
                    else begin e = qp0.pop_front(); chk("p0 read data", p0_mem_read_data, e); end
                end
                if (p1_mem_ready) begin
                    if (qp1.size() == 0) flag("p1 unexpected mem_ready");
                    else begin e = qp1.pop_front(); chk("p1 read data", p1_mem_read_data, e); end
                end
                if (mem_read_valid || mem_write_valid) begin
                    if (qd.size() == 0) flag("unexpected downstream issue");
                    else begin
                        d = qd.pop_front();
                        chk("issue write_valid", 32'(mem_write_valid), 32'(d.we));
                        chk("issue read_valid", 32'(mem_read_valid), 32'(!d.we));
                        chk("issue addr", mem_addr, d.addr);
                        chk("issue width", 32'(mem_width), 32'(d.width));
                        if (d.we) chk("issue wdata", mem_write_data, d.wdata);
                    end
                end
            end
        end
    endtask

    task automatic memory();
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (rst) pend = 1'b0;
            if (pend && mem_auto) begin
                mem_ready     = 1'b1;
                mem_read_data = mem_fn(pend_addr);
                pend          = 1'b0;
            end
            if ((mem_read_valid || mem_write_valid) && mem_auto && !rst) begin
                pend      = 1'b1;
                pend_addr = mem_addr;
            end
        end
    endtask

    initial begin
        vec_t vt [6];
        vt[0] = '{0, 1'b0, 32'h100,  32'h0,         2'd2, 32'h0100_FEFF};
        vt[1] = '{1, 1'b0, 32'h204,  32'h0,         2'd1, 32'h0204_FDFB};
        vt[2] = '{0, 1'b1, 32'h108,  32'hCAFE_0001, 2'd2, 32'h0100_FEFF};
        vt[3] = '{1, 1'b1, 32'h20A,  32'h0000_BEEF, 2'd1, 32'h0204_FDFB};
        vt[4] = '{0, 1'b0, 32'h10,   32'h0,         2'd0, 32'h1234_5678};
        vt[5] = '{1, 1'b0, 32'hFFFC, 32'h0,         2'd2, 32'hFFFC_0003};

        p0_mem_addr = '0; p0_mem_read_valid = 0; p0_mem_write_valid = 0;
        p0_mem_write_data = '0; p0_mem_width = '0;
        p1_mem_addr = '0; p1_mem_read_valid = 0; p1_mem_write_valid = 0;
        p1_mem_write_data = '0; p1_mem_width = '0;
        mem_ready = 1'b0; mem_read_data = '0;
        mem_auto = 1'b1; pend = 1'b0; pend_addr = '0;
        flush();

        fork
            monitor();
            memory();
        join_none

        // Reset state, reached before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("reset mem_read_valid", 32'(mem_read_valid), 0);
        chk("reset mem_write_valid", 32'(mem_write_valid), 0);
        chk("reset p0_mem_ready", 32'(p0_mem_ready), 0);
        chk("reset p1_mem_ready", 32'(p1_mem_ready), 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset p0_mem_read_data", p0_mem_read_data, 0);
        chk("reset protocol_error", 32'(protocol_error), 0);
        chk("reset timeout_error", 32'(timeout_error), 0);
        tick(); tick();
        rst = 1'b0;

        // Single read, exact latency.
        tick(); req(0, 1, 0, 32'h10, 32'h0, 2'd2);
        tick(); clr_req(0);
        @(negedge clk);
        chk("single: mem_read_valid cycle1", 32'(mem_read_valid), 1);
        chk("single: mem_addr", mem_addr, 32'h10);
        chk("single: mem_width", 32'(mem_width), 2);
        tick(); @(negedge clk);
        chk("single: p0_mem_ready cycle2", 32'(p0_mem_ready), 0);
        tick(); @(negedge clk);
        chk("single: p0_mem_ready cycle3", 32'(p0_mem_ready), 1);
        chk("single: p0_mem_read_data", p0_mem_read_data, 32'h1234_5678);
        chk("single: p1_mem_ready", 32'(p1_mem_ready), 0);
        wait_idle("single");
        chk("single: p1 read data untouched", p1_mem_read_data, 0);

        // Simultaneous requests; the queue order encodes the grant order.
        do_reset();
        tick(); req(0, 1, 0, 32'h80, 0, 2'd2); req(1, 1, 0, 32'h84, 0, 2'd2);
        tick(); clr_req(0); clr_req(1);
        wait_idle("round1");
        tick(); req(0, 1, 0, 32'h88, 0, 2'd2);
        tick(); clr_req(0);
        wait_idle("p0 solo");
        tick(); req(1, 1, 0, 32'h94, 0, 2'd2); req(0, 1, 0, 32'h90, 0, 2'd2);
        tick(); clr_req(0); clr_req(1);
        wait_idle("round2");
        tick(); req(1, 1, 0, 32'h9C, 0, 2'd2); req(0, 1, 0, 32'h98, 0, 2'd2);
        tick(); clr_req(0); clr_req(1);
        wait_idle("round3");
        chk("rr: p0 final data", p0_mem_read_data, 32'h0098_FF67);
        chk("rr: p1 final data", p1_mem_read_data, 32'h009C_FF63);

        // Table-driven single transactions.
        for (int i = 0; i < 6; i++) begin
            tick();
            req(vt[i].port, !vt[i].we, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].width);
            tick(); clr_req(vt[i].port);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d read data", i),
                (vt[i].port == 1) ? p1_mem_read_data : p0_mem_read_data, vt[i].exp_rdata);
        end

        // p1 byte store arriving while a p0 read waits.
        tick(); req(0, 1, 0, 32'h30, 0, 2'd2);
        tick(); clr_req(0); req(1, 0, 1, 32'h20, 32'hAB, 2'd0);
        tick(); clr_req(1);
        tick(); @(negedge clk);
        chk("wdr: p0_mem_ready", 32'(p0_mem_ready), 1);
        chk("wdr: write not yet issued", 32'(mem_write_valid), 0);
        tick(); @(negedge clk);
        chk("wdr: mem_write_valid", 32'(mem_write_valid), 1);
        chk("wdr: mem_write_data", mem_write_data, 32'hAB);
        chk("wdr: mem_width", 32'(mem_width), 0);
        wait_idle("wdr");
        chk("wdr: p1 read data unchanged", p1_mem_read_data, 32'hFFFC_0003);

        // Protocol violations.
        chk("proto: clean before", 32'(protocol_error), 0);
        tick(); req(0, 1, 0, 32'h40, 0, 2'd2);
        tick(); set_req(0, 1, 0, 32'h48, 0, 2'd2);
        tick(); clr_req(0);
        wait_idle("proto drop");
        chk("proto: error after drop", 32'(protocol_error), 1);
        do_reset();
        chk("proto: cleared by reset", 32'(protocol_error), 0);
        tick(); req(0, 1, 1, 32'h44, 32'h55, 2'd2);
        tick(); clr_req(0);
        wait_idle("proto dual");
        chk("proto: error after dual valid", 32'(protocol_error), 1);
        repeat (3) tick();
        chk("proto: error sticky", 32'(protocol_error), 1);
        chk("proto: dual is write, data kept", p0_mem_read_data, 0);

        // Watchdog abort with a silent memory.
        mem_auto = 1'b0;
        chk("to: clean before", 32'(timeout_error), 0);
        tick(); set_req(0, 1, 0, 32'h50, 0, 2'd2);
        exp_issue(1'b0, 32'h50, 0, 2'd2);
        model_rd[0] = 32'hDEAD_BEEF;
        exp_done(0, 32'hDEAD_BEEF);
        tick(); clr_req(0);
        tick(); tick(); tick();
        @(negedge clk);
        chk("to: no ready cycle4", 32'(p0_mem_ready), 0);
        chk("to: no error cycle4", 32'(timeout_error), 0);
        tick(); @(negedge clk);
        chk("to: p0_mem_ready cycle5", 32'(p0_mem_ready), 1);
        chk("to: abort data", p0_mem_read_data, 32'hDEAD_BEEF);
        chk("to: timeout_error", 32'(timeout_error), 1);
        mem_auto = 1'b1;
        wait_idle("to abort");
        tick(); req(0, 1, 0, 32'h58, 0, 2'd2);
        tick(); clr_req(0);
        wait_idle("to recover");
        chk("to: next read served", p0_mem_read_data, 32'h0058_FFA7);
        chk("to: error sticky", 32'(timeout_error), 1);

        // Asynchronous reset while a transaction waits.
        mem_auto = 1'b0;
        tick(); set_req(0, 1, 0, 32'h60, 32'h1111, 2'd2);
        exp_issue(1'b0, 32'h60, 0, 2'd2);
        tick(); clr_req(0);
        tick();
        #1 rst = 1'b1;
        flush();
        #1;
        chk("rst: mem_addr", mem_addr, 0);
        chk("rst: mem_write_data", mem_write_data, 0);
        chk("rst: mem_width", 32'(mem_width), 0);
        chk("rst: p0_mem_read_data", p0_mem_read_data, 0);
        chk("rst: timeout_error", 32'(timeout_error), 0);
        chk("rst: protocol_error", 32'(protocol_error), 0);
        tick(); tick();
        rst = 1'b0;
        tick(); mem_ready = 1'b1; mem_read_data = 32'h5555_AAAA;
        tick(); mem_ready = 1'b0;
        repeat (3) tick();
        chk("rst: stale ready ignored p0", p0_mem_read_data, 0);
        chk("rst: stale ready ignored p1", p1_mem_read_data, 0);
        mem_auto = 1'b1;
        tick(); req(1, 1, 0, 32'h70, 0, 2'd2);
        tick(); clr_req(1);
        wait_idle("rst recover");
        chk("rst: p1 served after reset", p1_mem_read_data, 32'h0070_FF8F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
